// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Default-configuration sizes; instances derive their own from parameters.
  localparam int DEF_NREQ  = 2;
  localparam int DEF_EXTRA = 4;
  localparam int DW        = (2 ** DEF_EXTRA) * 8;
  localparam int OWN_W     = $clog2(DEF_NREQ);

  // Data word width for a given extra (byte-count) field width.
  function automatic int dw_of(input int extra);
    return (2 ** extra) * 8;
  endfunction

  // Requester index width; never narrower than one bit.
  function automatic int own_w_of(input int nreq);
    return (nreq < 2) ? 1 : $clog2(nreq);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first asserted request at or above rr_ptr, wrapping to 0.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = own_w_of(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic            any,
  output logic [IW-1:0]   idx
);

  // Scan from the farthest candidate down so the one closest to rr_ptr wins.
  always_comb begin
    int j;
    j   = 0;
    any = |req;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(rr_ptr) + k) % NREQ;
      if (req[j]) idx = IW'(j);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory read port between NREQ requesters, round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int AW      = 4,
  parameter int EXTRA   = 4,
  parameter int LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*(AW+1)-1:0]    req_addr,
  input  logic [NREQ*EXTRA-1:0]     req_extra,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [dw_of(EXTRA)-1:0]   rsp_data,
  output logic                      rsp_error,
  output logic                      busy,
  output logic [AW:0]               mem_addr,
  output logic [EXTRA-1:0]          mem_extra,
  input  logic [dw_of(EXTRA)-1:0]   mem_data,
  input  logic                      mem_error
);

  localparam int IW = own_w_of(NREQ);
  localparam int CW = 3;  // LATENCY is at most 7, so the count never exceeds 6

  state_t                 state_q, state_d;
  logic [IW-1:0]          rr_ptr_q, owner_q;
  logic [CW-1:0]          wait_cnt_q;
  logic [NREQ-1:0]        gnt_q, rsp_valid_q;
  logic [dw_of(EXTRA)-1:0] rsp_data_q;
  logic                   rsp_error_q;
  logic [AW:0]            mem_addr_q;
  logic [EXTRA-1:0]       mem_extra_q;

  logic                   pick_any;
  logic [IW-1:0]          pick_idx;
  logic                   start, finish;
  logic [NREQ-1:0]        pick_oh, owner_oh;
  logic [IW-1:0]          rr_next;

  rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .any    (pick_any),
    .idx    (pick_idx)
  );

  // State register; reset drops any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: IDLE -> WAIT on any request, WAIT until the count expires, one RESP cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_any) state_d = WAIT;
      WAIT:    if (wait_cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decoded strobes, one-hot selects and the pointer that follows the current owner.
  always_comb begin
    busy     = (state_q != IDLE);
    start    = (state_q == IDLE) && pick_any;
    finish   = (state_q == RESP);
    pick_oh  = '0;
    pick_oh[pick_idx] = 1'b1;
    owner_oh = '0;
    owner_oh[owner_q] = 1'b1;
    rr_next  = (int'(owner_q) == NREQ - 1) ? '0 : owner_q + 1'b1;
  end

  // Ownership, grant pulse, wait counter and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      wait_cnt_q <= '0;
      gnt_q      <= '0;
    end else begin
      gnt_q <= '0;
      if (start) begin
        owner_q    <= pick_idx;
        gnt_q      <= pick_oh;
        wait_cnt_q <= CW'(LATENCY - 1);
      end else if (state_q == WAIT && wait_cnt_q != '0) begin
        wait_cnt_q <= wait_cnt_q - 1'b1;
      end
      if (finish) rr_ptr_q <= rr_next;
    end
  end

  // Memory-side address/extra latch; held outside a grant since reads are side-effect free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr_q  <= '0;
      mem_extra_q <= '0;
    end else if (start) begin
      mem_addr_q  <= req_addr[int'(pick_idx)*(AW+1) +: (AW+1)];
      mem_extra_q <= req_extra[int'(pick_idx)*EXTRA +: EXTRA];
    end
  end

  // Response capture: data held until the next response, valid is a single pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      if (finish) begin
        rsp_valid_q <= owner_oh;
        rsp_data_q  <= mem_data;
        rsp_error_q <= mem_error;
      end
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_error = rsp_error_q;
  assign mem_addr  = mem_addr_q;
  assign mem_extra = mem_extra_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random-stimulus bench: two arbiters (LATENCY 1 and 3) against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 4;
  localparam int EXTRA = 4;
  localparam int DW   = 128;
  localparam logic [AW:0] UPPER = 5'd23;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   stop = 1'b0;

  always #5 clk = ~clk;

  // ROM image: byte at address a is 8'hA0 ^ (3*a).
  function automatic logic [7:0] rom_byte(input logic [AW:0] a);
    return 8'hA0 ^ (8'(a) * 8'd3);
  endfunction

  // Word returned for a read of n bytes from a, little-endian, address wraps.
  function automatic logic [DW-1:0] rom_word(input logic [AW:0] a, input logic [EXTRA-1:0] n);
    logic [DW-1:0] w;
    w = '0;
    for (int b = 0; b < 16; b++)
      if (b < int'(n)) w[b*8 +: 8] = rom_byte(a + (AW+1)'(b));
    return w;
  endfunction

  function automatic logic rom_err(input logic [AW:0] a);
    return a > UPPER;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int LAT = (g == 0) ? 1 : 3;

    logic [NREQ-1:0]        req, gnt, rsp_valid;
    logic [NREQ*(AW+1)-1:0] req_addr;
    logic [NREQ*EXTRA-1:0]  req_extra;
    logic [DW-1:0]          rsp_data, mem_data;
    logic                   rsp_error, busy, mem_error;
    logic [AW:0]            mem_addr;
    logic [EXTRA-1:0]       mem_extra;
    logic [AW:0]            pa [LAT];
    logic [EXTRA-1:0]       pe [LAT];

    mem_port_arbiter #(.NREQ(NREQ), .AW(AW), .EXTRA(EXTRA), .LATENCY(LAT)) dut (
      .clk(clk), .reset(rst_n), .req(req), .req_addr(req_addr), .req_extra(req_extra),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
      .busy(busy), .mem_addr(mem_addr), .mem_extra(mem_extra),
      .mem_data(mem_data), .mem_error(mem_error)
    );

    // Memory stub: LAT register stages between address and data.
    always @(posedge clk) begin
      pa[0] <= mem_addr;
      pe[0] <= mem_extra;
      for (int s = 1; s < LAT; s++) begin
        pa[s] <= pa[s-1];
        pe[s] <= pe[s-1];
      end
    end
    assign mem_data  = rom_word(pa[LAT-1], pe[LAT-1]);
    assign mem_error = rom_err(pa[LAT-1]);

    // Model: each accepted request is a scheduled transaction (grant at +1, response at +LAT+2).
    initial begin
      int cyc, free_at, gnt_cyc, rsp_cyc, rr, own;
      logic [AW:0] addr_m, pend_addr;
      logic [EXTRA-1:0] extra_m, pend_extra;
      logic [DW-1:0] data_m, pend_data;
      logic err_m, pend_err;
      logic [NREQ-1:0] eg, ev;
      cyc = 0; free_at = 0; gnt_cyc = -1; rsp_cyc = -1; rr = 0; own = 0;
      addr_m = '0; extra_m = '0; data_m = '0; err_m = 1'b0;
      pend_addr = '0; pend_extra = '0; pend_data = '0; pend_err = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          check("reset gnt", DW'(gnt), '0);
          check("reset rsp_valid", DW'(rsp_valid), '0);
          check("reset rsp_data", rsp_data, '0);
          check("reset rsp_error", DW'(rsp_error), '0);
          check("reset busy", DW'(busy), '0);
          check("reset mem_addr", DW'(mem_addr), '0);
          check("reset mem_extra", DW'(mem_extra), '0);
          free_at = cyc; gnt_cyc = -1; rsp_cyc = -1; rr = 0;
          addr_m = '0; extra_m = '0; data_m = '0; err_m = 1'b0;
        end else begin
          if (cyc == gnt_cyc) begin addr_m = pend_addr; extra_m = pend_extra; end
          if (cyc == rsp_cyc) begin data_m = pend_data; err_m = pend_err; end
          eg = '0; ev = '0;
          if (cyc == gnt_cyc) eg[own] = 1'b1;
          if (cyc == rsp_cyc) ev[own] = 1'b1;
          check("gnt", DW'(gnt), DW'(eg));
          check("rsp_valid", DW'(rsp_valid), DW'(ev));
          check("rsp_data", rsp_data, data_m);
          if (cyc == rsp_cyc) check("rsp_error", DW'(rsp_error), DW'(err_m));
          check("busy", DW'(busy), DW'(cyc < free_at));
          check("mem_addr", DW'(mem_addr), DW'(addr_m));
          check("mem_extra", DW'(mem_extra), DW'(extra_m));
          if (cyc >= free_at && req != '0) begin
            own        = pick(req, rr);
            pend_addr  = req_addr[own*(AW+1) +: (AW+1)];
            pend_extra = req_extra[own*EXTRA +: EXTRA];
            pend_data  = rom_word(pend_addr, pend_extra);
            pend_err   = rom_err(pend_addr);
            gnt_cyc    = cyc + 1;
            rsp_cyc    = cyc + LAT + 2;
            free_at    = rsp_cyc;
            rr         = (own + 1) % NREQ;
          end
        end
        cyc++;
      end
    end

    // Requesters: one directed read, then random hold/withdraw/re-request traffic.
    initial begin
      req = '0; req_addr = '0; req_extra = '0;
      wait (rst_n);
      @(posedge clk); #1;
      req = 2'b01;
      req_addr[0 +: AW+1] = 5'h03;
      req_extra[0 +: EXTRA] = 4'd4;
      @(posedge clk); #1;
      check("single gnt", DW'(gnt), DW'(2'b01));
      check("single mem_addr", DW'(mem_addr), DW'(5'h03));
      req = '0;
      repeat (LAT) begin
        @(posedge clk); #1;
        check("single mem_addr hold", DW'(mem_addr), DW'(5'h03));
        check("single rsp early", DW'(rsp_valid), '0);
      end
      @(posedge clk); #1;
      check("single rsp_valid", DW'(rsp_valid), DW'(2'b01));
      check("single rsp_data", rsp_data, DW'(32'hB2AF_ACA9));
      check("single rsp_error", DW'(rsp_error), '0);
      while (!stop) begin
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) begin
          if (req[i] && gnt[i]) begin
            req[i] = ($urandom_range(0, 3) == 0);
            req_addr[i*(AW+1) +: (AW+1)] = (AW+1)'($urandom_range(0, 31));
            req_extra[i*EXTRA +: EXTRA]  = EXTRA'($urandom_range(0, 15));
          end else if (req[i]) begin
            if ($urandom_range(0, 9) == 0) req[i] = 1'b0;
          end else if ($urandom_range(0, 2) == 0) begin
            req[i] = 1'b1;
            req_addr[i*(AW+1) +: (AW+1)] = (AW+1)'($urandom_range(0, 31));
            req_extra[i*EXTRA +: EXTRA]  = EXTRA'($urandom_range(0, 15));
          end
        end
      end
      req = '0;
    end
  end

  // Run control: model pins, random phase, reset in the middle of a wait, random phase.
  initial begin
    int n;
    check("model rom 3..6", rom_word(5'h03, 4'd4), DW'(32'hB2AF_ACA9));
    check("model err 24", DW'(rom_err(5'd24)), DW'(1'b1));
    check("model err 23", DW'(rom_err(5'd23)), '0);
    check("model pick wrap", DW'(pick(2'b11, 1)), DW'(1));
    check("model pick skip", DW'(pick(2'b01, 1)), DW'(0));
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (400) @(posedge clk);
    #1;
    n = 0;
    while (u[1].gnt == '0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL reset-mid-wait: no grant seen within 100 cycles, need one");
    end
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (400) @(posedge clk);
    stop = 1'b1;
    repeat (12) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
